mips_timer: RTL and testbench
=============================

MIPS_TIMER -- requirements
Module: mips_timer

Interface
REQ-001 SHALL provide parameter CNT_W, default 32, giving the width of the LOAD and COUNT registers (legal range 8..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cs  input  1  chip select; the CPU data-bus access targets this block.
REQ-005 SHALL have port memwrite  input  1  write strobe; it is qualified by cs.
REQ-006 SHALL have port addr  input  3  word index, equal to CPU address bits [4:2].
REQ-007 SHALL have port wdata  input  32  store data.
REQ-008 SHALL have port rdata  output  32  load data, combinational from addr, valid in the same cycle.
REQ-009 SHALL have port irq  output  1  interrupt request, level-sensitive, active-high.

Function
REQ-010 SHALL map the registers as follows: idx0 CTRL (bit0 EN, bit1 AUTO, bit2 IE); idx1 LOAD; idx2 COUNT; idx3 STATUS (bit0 EXP); idx4 PRESC (8 bits, see Configuration); idx5-7 reserved, reading 0 and ignoring writes.
REQ-011 SHALL perform a write on the rising edge of clk when cs=1 and memwrite=1; otherwise no register changes due to the bus.
REQ-012 SHALL return rdata = the addressed register zero-extended to 32 bits when cs=1, and 0 when cs=0; unused CTRL bits read 0.
REQ-013 SHALL write CTRL and LOAD directly; a write to COUNT loads COUNT with wdata[CNT_W-1:0].
REQ-014 SHALL treat STATUS as write-1-to-clear: wdata[0]=1 clears EXP and wdata[0]=0 leaves it unchanged.
REQ-015 SHALL generate a tick every cycle with EN=1 when the prescaler is compiled out (see Configuration).
REQ-016 SHALL, on a tick with COUNT!=0, decrement COUNT by 1.
REQ-017 SHALL, on a tick with COUNT==0, generate an expire event: set EXP; if AUTO=1, load COUNT with LOAD; if AUTO=0, clear EN and hold COUNT at 0.
REQ-018 SHALL therefore give an auto-reload period of LOAD+1 ticks.
REQ-019 SHALL let a bus write to COUNT in the same cycle as a tick take priority; that tick is discarded.
REQ-020 SHALL keep EXP=1 when an expire event and a STATUS clear occur in the same cycle (set wins).
REQ-021 SHALL let the written EN value take priority when a CTRL write and a one-shot expire occur in the same cycle; EXP is still set.
REQ-022 SHALL drive irq = EXP & IE combinationally; irq stays asserted until EXP is cleared or IE is written 0.
REQ-023 SHALL hold COUNT when EN=0; clearing EN does not clear EXP.

Reset
REQ-024 SHALL, while reset_n=0, immediately force CTRL=0, LOAD=0, COUNT=0, EXP=0, PRESC=0 and the prescale counter=0, independent of clk.
REQ-025 SHALL give irq=0 during and after reset until a new expire event occurs with IE=1.
REQ-026 SHALL abandon any countdown in progress when reset is asserted mid-count; no expire event occurs.

Configuration
REQ-027 SHALL, when macro MIPS_TIMER_PRESCALE_EN is defined, implement an 8-bit PRESC register at idx4 and an 8-bit prescale counter.
REQ-028 SHALL, with MIPS_TIMER_PRESCALE_EN defined and EN=1, increment the prescale counter every cycle; when it equals PRESC it produces a tick and wraps to 0, so one tick occurs every PRESC+1 cycles.
REQ-029 SHALL, with MIPS_TIMER_PRESCALE_EN defined, clear the prescale counter whenever EN=0 or PRESC is written.
REQ-030 SHALL, when MIPS_TIMER_PRESCALE_EN is undefined, omit the PRESC register and prescale counter; idx4 reads 0 and writes to it are ignored.

Verification
REQ-031 SHALL cover: LOAD=3, COUNT=3, CTRL=0b111 -> COUNT reads 3,2,1,0 in consecutive cycles, then EXP=1, irq=1 and COUNT=3 on the next cycle.
REQ-032 SHALL cover: one-shot with COUNT=2, CTRL=0b101 -> after 3 ticks EXP=1 and CTRL reads 0b100; COUNT then holds 0 for 10 further cycles.
REQ-033 SHALL cover: a STATUS write of 1 in the same cycle as an expire -> EXP reads 1; a STATUS write of 1 on the next cycle -> EXP=0 and irq=0.
REQ-034 SHALL cover: a COUNT write of 0x10 in a tick cycle while COUNT=5 -> COUNT reads 0x10 in the following cycle.
REQ-035 SHALL cover: with MIPS_TIMER_PRESCALE_EN defined, PRESC=4 and COUNT=1 -> COUNT decrements once every 5 cycles and EXP sets 10 cycles after EN is set.
REQ-036 SHALL cover: reset_n pulsed low between clock edges mid-count -> all registers read 0 and irq=0 before the next clk edge.

Source files
------------

// File: rtl/mips_timer.sv
// Memory-mapped countdown timer with auto-reload, write-1-to-clear expiry flag
// and level irq. Optional 8-bit prescaler enabled by MIPS_TIMER_PRESCALE_EN.
// Ports: clk, reset_n (async low), cs/memwrite/addr/wdata bus write,
//        rdata combinational read data, irq = EXP & IE.
module mips_timer #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        memwrite,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic             en;
  logic             auto_rl;
  logic             ie;
  logic             exp_flag;
  logic [CNT_W-1:0] load;
  logic [CNT_W-1:0] count;

  logic wr;
  logic wr_ctrl;
  logic wr_load;
  logic wr_count;
  logic wr_stat;
  logic tick;
  logic expire;

  assign wr       = cs & memwrite;
  assign wr_ctrl  = wr & (addr == 3'd0);
  assign wr_load  = wr & (addr == 3'd1);
  assign wr_count = wr & (addr == 3'd2);
  assign wr_stat  = wr & (addr == 3'd3);

`ifdef MIPS_TIMER_PRESCALE_EN
  logic       wr_presc;
  logic [7:0] presc;
  logic [7:0] pcnt;

  assign wr_presc = wr & (addr == 3'd4);
  assign tick     = en & (pcnt == presc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      pcnt  <= '0;
    end else begin
      if (wr_presc)
        presc <= wdata[7:0];
      if (!en || wr_presc || tick)
        pcnt <= '0;
      else
        pcnt <= pcnt + 8'd1;
    end
  end
`else
  assign tick = en;
`endif

  // A bus write to COUNT swallows the coincident tick, expiry included.
  assign expire = tick & ~wr_count & (count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      load     <= '0;
      count    <= '0;
      exp_flag <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en      <= wdata[0];
        auto_rl <= wdata[1];
        ie      <= wdata[2];
      end else if (expire && !auto_rl) begin
        en <= 1'b0;
      end

      if (wr_load)
        load <= wdata[CNT_W-1:0];

      if (wr_count)
        count <= wdata[CNT_W-1:0];
      else if (tick && count != '0)
        count <= count - 1'b1;
      else if (expire && auto_rl)
        count <= load;

      // Set beats a coincident clear.
      if (expire)
        exp_flag <= 1'b1;
      else if (wr_stat && wdata[0])
        exp_flag <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (cs) begin
      case (addr)
        3'd0:    rdata = {29'd0, ie, auto_rl, en};
        3'd1:    rdata = 32'(load);
        3'd2:    rdata = 32'(count);
        3'd3:    rdata = {31'd0, exp_flag};
`ifdef MIPS_TIMER_PRESCALE_EN
        3'd4:    rdata = {24'd0, presc};
`endif
        default: rdata = '0;
      endcase
    end
  end

  assign irq = exp_flag & ie;

endmodule

// File: tb/tb_mips_timer.sv
// Self-checking bench for mips_timer: directed scenarios plus random bus
// traffic, all compared against a cycle-level behavioural model.
module tb_mips_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic        memwrite = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  always #10 clk = ~clk;

  mips_timer dut (
    .clk(clk),
    .reset_n(reset_n),
    .cs(cs),
    .memwrite(memwrite),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .irq(irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit      m_en, m_auto, m_ie, m_exp;
  int unsigned m_load, m_count;
  int      m_presc, m_pcnt;

  logic [31:0] last_rd;
  logic        last_irq;

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0;
    m_load = 0; m_count = 0; m_presc = 0; m_pcnt = 0;
  endtask

  function automatic logic [31:0] m_read(input bit c, input int a);
    if (!c) return 32'd0;
    case (a)
      0: return {29'd0, m_ie, m_auto, m_en};
      1: return m_load;
      2: return m_count;
      3: return {31'd0, m_exp};
      4: return m_presc[31:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input bit c, input bit w,
                            input int a, input logic [31:0] d);
    bit wr, tick, cw, expire, pw;
    bit n_en, n_auto, n_ie, n_exp;
    int unsigned n_load, n_count;
    int n_presc, n_pcnt;
    wr = c && w;
    cw = wr && a == 2;
`ifdef MIPS_TIMER_PRESCALE_EN
    pw = wr && a == 4;
`else
    pw = 0;
`endif
    tick = m_en && (m_pcnt == m_presc);
    expire = tick && !cw && m_count == 0;
    n_en = m_en; n_auto = m_auto; n_ie = m_ie;
    if (wr && a == 0) begin
      n_en = d[0]; n_auto = d[1]; n_ie = d[2];
    end else if (expire && !m_auto) n_en = 0;
    n_load = (wr && a == 1) ? d : m_load;
    if (cw) n_count = d;
    else if (tick) n_count = (m_count != 0) ? m_count - 1 :
                             (m_auto ? m_load : 0);
    else n_count = m_count;
    if (expire) n_exp = 1;
    else if (wr && a == 3 && d[0]) n_exp = 0;
    else n_exp = m_exp;
    n_presc = pw ? int'(d[7:0]) : m_presc;
    n_pcnt = (!m_en || pw) ? 0 : (m_pcnt + 1) % (m_presc + 1);
    m_en = n_en; m_auto = n_auto; m_ie = n_ie; m_exp = n_exp;
    m_load = n_load; m_count = n_count;
    m_presc = n_presc; m_pcnt = n_pcnt;
  endtask

  task automatic cycle(input bit c, input bit w,
                       input int a, input logic [31:0] d);
    @(negedge clk);
    cs = c; memwrite = w; addr = a[2:0]; wdata = d;
    #1;
    last_rd = rdata;
    last_irq = irq;
    check($sformatf("rdata a%0d", a), rdata, m_read(c, a));
    check("irq", {31'd0, irq}, {31'd0, m_exp & m_ie});
    @(posedge clk);
    model_step(c, w, a, d);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    cycle(1, 1, a, d);
  endtask

  task automatic rd(input int a);
    cycle(1, 0, a, 32'd0);
  endtask

  task automatic quiesce();
    wr(0, 0);
    wr(3, 1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      rd(i);
      check("reset reg", last_rd, 32'd0);
    end
    check("reset irq", {31'd0, last_irq}, 32'd0);

    // Auto-reload period LOAD+1
    wr(1, 3);
    wr(2, 3);
    wr(0, 7);
    rd(2); check("ar c3", last_rd, 3);
    rd(2); check("ar c2", last_rd, 2);
    rd(2); check("ar c1", last_rd, 1);
    rd(2); check("ar c0", last_rd, 0);
    rd(2); check("ar reload", last_rd, 3);
    check("ar irq", {31'd0, last_irq}, 32'd1);
    rd(3); check("ar exp", last_rd, 1);
    quiesce();

    // One-shot
    wr(2, 2);
    wr(0, 5);
    rd(0); rd(0); rd(0);
    rd(0); check("os ctrl", last_rd, 4);
    for (int i = 0; i < 10; i++) begin
      rd(2); check("os hold", last_rd, 0);
    end
    rd(3); check("os exp", last_rd, 1);
    quiesce();

    // Clear coincident with expire loses; next clear wins
    wr(1, 2);
    wr(2, 1);
    wr(0, 7);
    rd(2); check("clr c1", last_rd, 1);
    wr(3, 1);
    rd(3); check("clr set wins", last_rd, 1);
    wr(3, 1);
    rd(3); check("clr done", last_rd, 0);
    check("clr irq", {31'd0, last_irq}, 32'd0);
    quiesce();

    // COUNT write beats tick
    wr(2, 5);
    wr(0, 1);
    wr(2, 32'h10);
    rd(2); check("cw prio", last_rd, 32'h10);
    quiesce();

`ifdef MIPS_TIMER_PRESCALE_EN
    wr(4, 4);
    wr(2, 1);
    wr(0, 1);
    for (int i = 1; i <= 10; i++) begin
      rd(2);
      check($sformatf("ps cnt%0d", i), last_rd, (i <= 5) ? 1 : 0);
    end
    rd(3); check("ps exp", last_rd, 1);
    quiesce();
    wr(4, 0);
`endif

    // Asynchronous reset mid-count
    wr(1, 20);
    wr(2, 20);
    wr(0, 7);
    rd(2); rd(2); rd(2);
    @(negedge clk);
    #1 reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cs = 1'b1; memwrite = 1'b0; addr = i[2:0];
      #1 check($sformatf("arst a%0d", i), rdata, 32'd0);
      check("arst irq", {31'd0, irq}, 32'd0);
    end
    #1 reset_n = 1'b1;
    rd(2); check("post rst cnt", last_rd, 0);
    rd(2); check("post rst hold", last_rd, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int a;
      bit c, w;
      logic [31:0] d;
      a = $urandom_range(0, 7);
      c = ($urandom_range(0, 9) != 0);
      w = ($urandom_range(0, 3) == 0);
      case (a)
        0: begin
          d = $urandom_range(0, 7);
          if ($urandom_range(0, 1) == 1) d[0] = 1'b1;
        end
        1, 2: d = $urandom_range(0, 10);
        3: d = $urandom_range(0, 1);
        4: d = $urandom_range(0, 3);
        default: d = $urandom;
      endcase
      cycle(c, w, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
